// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the alu_exec_seq execute sequencer.
package alu_exec_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Sequencer states: one instruction walks StIdle -> StRdA -> StRdB -> StExec -> StWb.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StExec = 3'd3,
    StWb   = 3'd4
  } state_e;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // Shift codes applied to operand B before the ALU
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath: shift B, apply the ALU op, derive {Z,N,V}.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op_i,
  input  logic [1:0]        shift_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] c_o,
  output logic [2:0]        status_o
);

  localparam int unsigned Msb = DATA_W - 1;

  logic [DATA_W-1:0] bs;
  logic [DATA_W-1:0] res;
  logic              ovf;

  // Barrel of one: shift B by at most one position
  always_comb begin
    bs = b_i;
    unique case (shift_i)
      SH_NONE: bs = b_i;
      SH_LSL:  bs = {b_i[Msb-1:0], 1'b0};
      SH_LSR:  bs = {1'b0, b_i[Msb:1]};
      SH_ASR:  bs = {b_i[Msb], b_i[Msb:1]};
      default: bs = b_i;
    endcase
  end

  // ALU result and signed overflow (only meaningful for ADD/SUB)
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        res = a_i + bs;
        ovf = (a_i[Msb] == bs[Msb]) && (res[Msb] != a_i[Msb]);
      end
      ALU_SUB: begin
        res = a_i - bs;
        ovf = (a_i[Msb] != bs[Msb]) && (res[Msb] != a_i[Msb]);
      end
      ALU_AND: res = a_i & bs;
      ALU_NOT: res = ~bs;
      default: res = '0;
    endcase
  end

  assign c_o      = res;
  assign status_o = {(res == '0), res[Msb], ovf};

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer in front of an 8x16 register file.
// Reads A (rn) then B (rm), executes, and writes the result back to rd.
// Optional macro ALU_SKIP_A_EN: NOT skips the A read (3-edge latency).
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [REG_AW-1:0] rf_readnum,
  output logic [REG_AW-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        status
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        shift_q, shift_d;
  logic [REG_AW-1:0] rm_q, rm_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [2:0]        status_q, status_d;
  logic [REG_AW-1:0] rf_readnum_q, rf_readnum_d;
  logic [REG_AW-1:0] rf_writenum_q, rf_writenum_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] alu_c;
  logic [2:0]        alu_status;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .op_i     (op_q),
    .shift_i  (shift_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .c_o      (alu_c),
    .status_o (alu_status)
  );

  // Next-state and datapath capture; every register holds unless its state updates it
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    shift_d       = shift_q;
    rm_d          = rm_q;
    rd_d          = rd_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    status_d      = status_q;
    rf_readnum_d  = rf_readnum_q;
    rf_writenum_d = rf_writenum_q;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d         = op;
          shift_d      = shift;
          rm_d         = rm;
          rd_d         = rd;
          // rn is only needed for the RD_A read, so it goes straight to the read port
          rf_readnum_d = rn;
          state_d      = StRdA;
`ifdef ALU_SKIP_A_EN
          // NOT ignores A, so go directly to the B read
          if (op == ALU_NOT) begin
            rf_readnum_d = rm;
            state_d      = StRdB;
          end
`endif
        end
      end
      StRdA: begin
        a_d          = rf_data_out;
        rf_readnum_d = rm_q;
        state_d      = StRdB;
      end
      StRdB: begin
        b_d     = rf_data_out;
        state_d = StExec;
      end
      StExec: begin
        c_d           = alu_c;
        status_d      = alu_status;
        rf_writenum_d = rd_q;
        state_d       = StWb;
      end
      StWb: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      op_q          <= '0;
      shift_q       <= '0;
      rm_q          <= '0;
      rd_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      status_q      <= '0;
      rf_readnum_q  <= '0;
      rf_writenum_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      shift_q       <= shift_d;
      rm_q          <= rm_d;
      rd_q          <= rd_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      status_q      <= status_d;
      rf_readnum_q  <= rf_readnum_d;
      rf_writenum_q <= rf_writenum_d;
      done_q        <= done_d;
    end
  end

  // Output decode: write enable only in StWb, busy in every non-idle state
  always_comb begin
    rf_readnum  = rf_readnum_q;
    rf_writenum = rf_writenum_q;
    rf_write    = (state_q == StWb);
    rf_data_in  = c_q;
    busy        = (state_q != StIdle);
    done        = done_q;
    result      = c_q;
    status      = status_q;
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq with a behavioural 8x16 register file.
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  shift;
  logic [2:0]  rn, rm, rd;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic        busy, done;
  logic [15:0] result;
  logic [2:0]  status;

  alu_exec_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .shift       (shift),
    .rn          (rn),
    .rm          (rm),
    .rd          (rd),
    .rf_data_out (rf_data_out),
    .rf_readnum  (rf_readnum),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .status      (status)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write on rising edge
  logic [15:0] regs [8];
  int wr_count   = 0;
  int done_count = 0;
  assign rf_data_out = regs[rf_readnum];

  always @(posedge clk) begin
    if (rf_write) begin
      regs[rf_writenum] <= rf_data_in;
      wr_count          <= wr_count + 1;
    end
  end

  always @(negedge clk) begin
    if (done) done_count <= done_count + 1;
  end

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] res;
    logic [2:0]  st;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int total  = 0;
  int passed = 0;

  // Reference: returns {result, Z, N, V}
  function automatic logic [18:0] model(input logic [1:0] o, input logic [1:0] s,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bs, r;
    logic        v;
    int          sum;
    case (s)
      2'd0:    bs = b;
      2'd1:    bs = b << 1;
      2'd2:    bs = b >> 1;
      default: bs = $unsigned($signed(b) >>> 1);
    endcase
    v = 1'b0;
    r = '0;
    case (o)
      2'd0: begin
        sum = int'($signed(a)) + int'($signed(bs));
        r   = sum[15:0];
        v   = (sum > 32767) || (sum < -32768);
      end
      2'd1: begin
        sum = int'($signed(a)) - int'($signed(bs));
        r   = sum[15:0];
        v   = (sum > 32767) || (sum < -32768);
      end
      2'd2:    r = a & bs;
      default: r = ~bs;
    endcase
    return {r, (r == 16'h0000), r[15], v};
  endfunction

  function automatic int exp_latency(input logic [1:0] o);
`ifdef ALU_SKIP_A_EN
    return (o == 2'b11) ? 3 : 4;
`else
    return (o == 2'b11) ? 4 : 4;
`endif
  endfunction

  task automatic set_reg(input int idx, input logic [15:0] val);
    @(negedge clk);
    regs[idx] <= val;
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [1:0] s, input logic [2:0] a_idx,
                          input logic [2:0] b_idx, input logic [2:0] d_idx, input string name);
    exp_t        e;
    logic [18:0] m;
    m      = model(o, s, regs[a_idx], regs[b_idx]);
    e.rd   = d_idx;
    e.res  = m[18:3];
    e.st   = m[2:0];
    e.lat  = exp_latency(o);
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [1:0] op_v, input logic [1:0] sh_v, input logic [2:0] rn_v,
                        input logic [2:0] rm_v, input logic [2:0] rd_v, input string name);
    exp_t e;
    int   busy_cnt;
    bit   got;
    int   wr0, dn0;
    @(negedge clk);
    push_exp(op_v, sh_v, rn_v, rm_v, rd_v, name);
    wr0   = wr_count;
    dn0   = done_count;
    op    = op_v;
    shift = sh_v;
    rn    = rn_v;
    rm    = rm_v;
    rd    = rd_v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    e = sb.pop_front();
    total++;
    if (!got) $display("FAIL %s done_timeout got no done want done within 12 cycles", e.name);
    else passed++;
    total++;
    if (result !== e.res) $display("FAIL %s result got %h want %h", e.name, result, e.res);
    else passed++;
    total++;
    if (status !== e.st) $display("FAIL %s status got %b want %b", e.name, status, e.st);
    else passed++;
    total++;
    if (regs[e.rd] !== e.res)
      $display("FAIL %s regfile R%0d got %h want %h", e.name, e.rd, regs[e.rd], e.res);
    else passed++;
    total++;
    if (busy_cnt !== e.lat) $display("FAIL %s busy_cycles got %0d want %0d", e.name, busy_cnt, e.lat);
    else passed++;
    total++;
    if (wr_count - wr0 !== 1) $display("FAIL %s writes got %0d want 1", e.name, wr_count - wr0);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || done_count - dn0 !== 1)
      $display("FAIL %s done_pulse got done=%b count=%0d want done=0 count=1", e.name, done,
               done_count - dn0);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    op      = '0;
    shift   = '0;
    rn      = '0;
    rm      = '0;
    rd      = '0;
    for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_write !== 1'b0)
      $display("FAIL reset_ctrl got busy=%b done=%b wr=%b want 0 0 0", busy, done, rf_write);
    else passed++;
    total++;
    if (result !== 16'h0 || status !== 3'b000)
      $display("FAIL reset_result got %h/%b want 0000/000", result, status);
    else passed++;
    total++;
    if (rf_readnum !== 3'd0 || rf_writenum !== 3'd0 || rf_data_in !== 16'h0)
      $display("FAIL reset_rf got rn=%0d wn=%0d din=%h want 0 0 0000", rf_readnum, rf_writenum,
               rf_data_in);
    else passed++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL idle_no_start busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_add();
    set_reg(0, 16'd7);
    set_reg(1, 16'd3);
    run_op(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, "add");
  endtask

  task automatic test_sub_flags();
    set_reg(1, 16'd3);
    set_reg(0, 16'd7);
    run_op(2'b01, 2'b00, 3'd1, 3'd0, 3'd3, "sub_neg");
    run_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd4, "sub_zero");
  endtask

  task automatic test_overflow();
    set_reg(4, 16'h7FFF);
    set_reg(5, 16'h0001);
    run_op(2'b00, 2'b00, 3'd4, 3'd5, 3'd6, "add_ovf");
    set_reg(4, 16'h8000);
    run_op(2'b01, 2'b00, 3'd4, 3'd5, 3'd7, "sub_ovf");
  endtask

  task automatic test_shift_and();
    set_reg(2, 16'hF0F0);
    set_reg(3, 16'h8001);
    run_op(2'b10, 2'b11, 3'd2, 3'd3, 3'd7, "and_asr");
    run_op(2'b10, 2'b10, 3'd2, 3'd3, 3'd7, "and_lsr");
    run_op(2'b00, 2'b01, 3'd2, 3'd3, 3'd5, "add_lsl");
  endtask

  task automatic test_not();
    set_reg(3, 16'h00FF);
    run_op(2'b11, 2'b00, 3'd0, 3'd3, 3'd1, "not");
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   wr0, dn0;
    logic [15:0] r0_before;
    set_reg(0, 16'd100);
    set_reg(1, 16'd23);
    @(negedge clk);
    r0_before = regs[0];
    push_exp(2'b00, 2'b00, 3'd0, 3'd1, 3'd5, "ignore_start");
    wr0   = wr_count;
    dn0   = done_count;
    op    = 2'b00;
    shift = 2'b00;
    rn    = 3'd0;
    rm    = 3'd1;
    rd    = 3'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // In RD_B now: a second request aimed at R0 must be dropped
    op    = 2'b11;
    rd    = 3'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    e = sb.pop_front();
    total++;
    if (wr_count - wr0 !== 1 || done_count - dn0 !== 1)
      $display("FAIL %s counts got wr=%0d done=%0d want 1 1", e.name, wr_count - wr0,
               done_count - dn0);
    else passed++;
    total++;
    if (regs[5] !== e.res) $display("FAIL %s R5 got %h want %h", e.name, regs[5], e.res);
    else passed++;
    total++;
    if (regs[0] !== r0_before)
      $display("FAIL %s R0 got %h want %h", e.name, regs[0], r0_before);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   got;
    set_reg(0, 16'd7);
    set_reg(1, 16'd3);
    @(negedge clk);
    push_exp(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, "b2b_first");
    op    = 2'b00;
    shift = 2'b00;
    rn    = 3'd0;
    rm    = 3'd1;
    rd    = 3'd2;
    start = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    total++;
    if (!got || regs[2] !== e.res)
      $display("FAIL %s R2 got %h done=%b want %h done=1", e.name, regs[2], got, e.res);
    else passed++;
    // Done cycle: retarget with rd aliasing both sources, start still held
    push_exp(2'b00, 2'b00, 3'd2, 3'd2, 3'd2, "b2b_alias");
    rn = 3'd2;
    rm = 3'd2;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept busy got %b want 1", busy);
    else passed++;
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    total++;
    if (!got || regs[2] !== e.res || result !== e.res)
      $display("FAIL %s R2 got %h result %h want %h", e.name, regs[2], result, e.res);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int wr0, dn0;
    set_reg(6, 16'h1234);
    @(negedge clk);
    wr0   = wr_count;
    dn0   = done_count;
    op    = 2'b00;
    shift = 2'b00;
    rn    = 3'd0;
    rm    = 3'd1;
    rd    = 3'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (rf_write !== 1'b0 || busy !== 1'b0 || result !== 16'h0 || status !== 3'b000)
      $display("FAIL reset_mid_outputs got wr=%b busy=%b res=%h st=%b want 0 0 0000 000",
               rf_write, busy, result, status);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (regs[6] !== 16'h1234 || wr_count - wr0 !== 0 || done_count - dn0 !== 0)
      $display("FAIL reset_mid_effects got R6=%h wr=%0d done=%0d want 1234 0 0", regs[6],
               wr_count - wr0, done_count - dn0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_flags();
    test_overflow();
    test_shift_and();
    test_not();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
